// File: rtl/dom_mask_rng_pkg.sv
// rtl/dom_mask_rng_pkg.sv - shared constants, FSM encoding and sizing helper for the DOM mask RNG
package dom_mask_rng_pkg;

  localparam logic [31:0] LFSR_POLY     = 32'h80200003;
  localparam logic [31:0] ZERO_SEED_SUB = 32'h00000001;

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    LOAD     = 2'd1,
    WARMUP   = 2'd2,
    RUN      = 2'd3
  } rng_state_e;

  // Blinding bits per multiplier input; the first-order two-share multiplier needs only one.
  function automatic int blind_nrnd(input int shares, input int foo);
    return ((foo == 1) && (shares == 2)) ? 1 : shares;
  endfunction

endpackage

// File: rtl/lfsr32_unrolled.sv
// rtl/lfsr32_unrolled.sv - 32 unrolled Galois LFSR steps, so every state bit is fresh per advance
module lfsr32_unrolled
  import dom_mask_rng_pkg::*;
(
  input  logic [31:0] StatexDI,
  output logic [31:0] NextxDO
);

  always_comb begin
    NextxDO = StatexDI;
    for (int i = 0; i < 32; i++) begin
      NextxDO = {1'b0, NextxDO[31:1]} ^ (NextxDO[0] ? LFSR_POLY : 32'h0);
    end
  end

endmodule

// File: rtl/dom_mask_rng.sv
// rtl/dom_mask_rng.sv - seedable LFSR source of remask (Z) and blinding (B) bits for DOM multipliers
module dom_mask_rng
  import dom_mask_rng_pkg::*;
#(
  parameter int SHARES                   = 2,
  parameter int FIRST_ORDER_OPTIMIZATION = 1,
  parameter int NUM_MULS                 = 1,
  parameter int WARMUP_CYCLES            = 16,
  localparam int BLIND_NRND = blind_nrnd(SHARES, FIRST_ORDER_OPTIMIZATION),
  localparam int Z_W        = SHARES * (SHARES - 1),
  localparam int B_W        = 2 * BLIND_NRND,
  localparam int MUL_W      = Z_W + B_W,
  localparam int RND_W      = NUM_MULS * MUL_W
) (
  input  logic             ClkxCI,
  input  logic             RstxBI,
  input  logic [31:0]      SeedxDI,
  input  logic             SeedValidxSI,
  output logic             SeedReadyxSO,
  input  logic             RndEnxSI,
  output logic             RndValidxSO,
  output logic [RND_W-1:0] RndxDO,
  output logic             BusyxSO
);

  localparam int LANES = (RND_W + 31) / 32;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

  rng_state_e       StatexDP, StatexDN;
  logic [IDX_W-1:0] IdxxDP, IdxxDN;
  logic [CNT_W-1:0] CntxDP, CntxDN;
  logic             ReadyxDP, ReadyxDN;
  logic [31:0]      LanexDP [LANES];
  logic [31:0]      LanexDN [LANES];
  logic [31:0]      LaneAdvxD [LANES];
  logic [31:0]      SeedWordxD;
  logic             SeedAccxS;
  logic             AdvancexS;

  // An all-zero lane would lock the LFSR forever.
  assign SeedWordxD = (SeedxDI == 32'h0) ? ZERO_SEED_SUB : SeedxDI;
  assign SeedAccxS  = SeedValidxSI & ReadyxDP;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lfsr32_unrolled u_lfsr (
      .StatexDI (LanexDP[k]),
      .NextxDO  (LaneAdvxD[k])
    );
  end

  always_comb begin
    StatexDN  = StatexDP;
    IdxxDN    = IdxxDP;
    CntxDN    = CntxDP;
    AdvancexS = 1'b0;
    case (StatexDP)
      UNSEEDED, LOAD, RUN: begin
        // Index is zero in UNSEEDED and RUN, so a seed there always lands in lane 0.
        if (SeedAccxS) begin
          if (IdxxDP == IDX_W'(LANES - 1)) begin
            StatexDN = WARMUP;
            IdxxDN   = '0;
          end else begin
            StatexDN = LOAD;
            IdxxDN   = IdxxDP + 1'b1;
          end
        end else if ((StatexDP == RUN) && RndEnxSI) begin
          AdvancexS = 1'b1;
        end
      end
      WARMUP: begin
        AdvancexS = 1'b1;
        if (CntxDP == CNT_W'(WARMUP_CYCLES - 1)) begin
          StatexDN = RUN;
          CntxDN   = '0;
        end else begin
          CntxDN = CntxDP + 1'b1;
        end
      end
      default: StatexDN = UNSEEDED;
    endcase
    ReadyxDN = (StatexDN != WARMUP);
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      LanexDN[k] = AdvancexS ? LaneAdvxD[k] : LanexDP[k];
      if (SeedAccxS && (IdxxDP == IDX_W'(k))) begin
        LanexDN[k] = SeedWordxD;
      end
    end
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      StatexDP <= UNSEEDED;
      IdxxDP   <= '0;
      CntxDP   <= '0;
      ReadyxDP <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        LanexDP[k] <= 32'(k + 1);
      end
    end else begin
      StatexDP <= StatexDN;
      IdxxDP   <= IdxxDN;
      CntxDP   <= CntxDN;
      ReadyxDP <= ReadyxDN;
      for (int k = 0; k < LANES; k++) begin
        LanexDP[k] <= LanexDN[k];
      end
    end
  end

  assign SeedReadyxSO = ReadyxDP;
  assign RndValidxSO  = (StatexDP == RUN);
  assign BusyxSO      = (StatexDP == LOAD) || (StatexDP == WARMUP);

  for (genvar b = 0; b < RND_W; b++) begin : g_out
    assign RndxDO[b] = LanexDP[b / 32][b % 32];
  end

endmodule

// File: doc/dom_mask_rng.md
Name: dom_mask_rng

Overview:
- Upstream fresh-randomness source for the DOM S-box datapath.
- Produces, every enabled cycle, the remask bits (Z) and blinding bits (B) consumed by a row of NUM_MULS DOM shared GF(2^2) multipliers.
- Built from seedable 32-bit Galois LFSR lanes behind a load/warm-up/run FSM with a seed handshake.

Parameters:
- SHARES, 2, number of masking shares (>=2).
- FIRST_ORDER_OPTIMIZATION, 1, selects blinding-bit count per multiplier.
- NUM_MULS, 1, number of GF(2^2) multipliers fed in parallel.
- WARMUP_CYCLES, 16, LFSR advance cycles after seeding before output is valid (>=1).

Derived constants:
- BLIND_NRND = 1 if FIRST_ORDER_OPTIMIZATION==1 and SHARES==2, else SHARES.
- Z_W = SHARES*(SHARES-1).
- B_W = 2*BLIND_NRND.
- MUL_W = Z_W+B_W.
- RND_W = NUM_MULS*MUL_W.
- LANES = ceil(RND_W/32).

Ports:
- ClkxCI  in  1  clock, rising edge.
- RstxBI  in  1  reset, asynchronous, active-low.
- SeedxDI  in  32  seed word.
- SeedValidxSI  in  1  seed word offered.
- SeedReadyxSO  out  1  seed word accepted when high together with SeedValidxSI.
- RndEnxSI  in  1  consumer takes current RndxDO this cycle.
- RndValidxSO  out  1  RndxDO holds fresh randomness.
- RndxDO  out  RND_W  mask bits. Multiplier m occupies [m*MUL_W +: MUL_W]; within that slice Z is bits [Z_W-1:0] and B is bits [MUL_W-1:Z_W].
- BusyxSO  out  1  high in LOAD or WARMUP.

Behaviour:
- LFSR lane step (one step): lsb=s[0]; s=s>>1; if lsb, s^=32'h80200003.
- Each lane update applies 32 unrolled steps per advance, so every output bit is fresh per advance.
- RndxDO = concatenation of lane states (lane 0 in LSBs), truncated to RND_W. It is registered and taken directly from lane flops.
- Reset values:
  - FSM=UNSEEDED.
  - Lane k = 32'h1+k.
  - RndValidxSO=0, SeedReadyxSO=0, BusyxSO=0.
  - Load index=0, warm-up counter=0.
  - RndxDO therefore shows the lane reset constants.
- FSM states: UNSEEDED, LOAD, WARMUP, RUN.
- UNSEEDED:
  - SeedReadyxSO=1, no advance.
  - SeedValidxSI high: seed word goes into lane 0 this edge, index becomes 1, state becomes LOAD.
  - If LANES==1, state goes directly to WARMUP.
- LOAD:
  - SeedReadyxSO=1.
  - Each accepted word is written into lane[index], then index increments.
  - The last word (index LANES-1) moves the state to WARMUP.
  - Gaps in SeedValidxSI are allowed; state holds.
- Zero guard: an all-zero seed word is stored as 32'h1.
- WARMUP:
  - SeedReadyxSO=0.
  - All lanes advance every cycle for exactly WARMUP_CYCLES cycles, then state becomes RUN.
  - RndValidxSO rises on the cycle RUN is entered.
- RUN:
  - RndValidxSO=1, SeedReadyxSO=1.
  - RndEnxSI=1: all lanes advance at the edge, so the new value is visible next cycle.
  - RndEnxSI=0: RndxDO is held.
- Reseed from RUN:
  - SeedValidxSI=1 in RUN accepts the word into lane 0 and moves the state to LOAD.
  - RndValidxSO=0 from the next cycle.
  - If RndEnxSI is high in the same cycle, the seed write has priority and there is no advance.
- RndEnxSI is ignored outside RUN.
- Reset asserted mid-LOAD or mid-WARMUP returns all state to reset values immediately. A partially loaded seed is discarded.
- Latency from the last seed accept to RndValidxSO=1 is WARMUP_CYCLES+1 edges.
- A lane never reaches state 0: the zero guard plus a non-zero reset value ensure this.
- Unused top bits of the last lane are not output but still advance.

Decomposition:
- Package dom_mask_rng_pkg holds:
  - the LFSR polynomial constant 32'h80200003;
  - the zero-seed substitute 32'h1;
  - FSM state encoding (2 bits);
  - function blind_nrnd(SHARES, FOO), shared with the multiplier instances.
- Sub-module lfsr32_unrolled:
  - combinational 32-step advance;
  - input state, output next state;
  - instantiated LANES times.

Test Plan:
- Reset, then SHARES=2, FOO=1, NUM_MULS=1 (RND_W=4, LANES=1): RndxDO=4'h1, RndValidxSO=0, SeedReadyxSO=1, BusyxSO=0.
- Seed 32'hDEADBEEF, WARMUP_CYCLES=16: BusyxSO=1 for exactly 16 cycles; RndValidxSO=1 on the 17th edge after accept; RndxDO equals the golden model (32 steps applied 16 times) truncated to 4 bits.
- NUM_MULS=12, SHARES=2, FOO=1 (RND_W=48, LANES=2):
  - Seed words 32'h0 then 32'h12345678, with a 3-cycle gap between them.
  - Required: the state holds in LOAD during the gap, lane 0 is loaded as 32'h1, and the output matches the golden model.
- RUN with RndEnxSI pattern 1,0,0,1: RndxDO changes only after the enabled cycles and is held bit-exact during the 0 cycles.
- In RUN, SeedValidxSI and RndEnxSI high together: no advance; RndValidxSO=0 next cycle; state is LOAD.
- RstxBI pulsed low mid-WARMUP (cycle 5): outputs return to reset values asynchronously, before the next clock edge; a later full reseed gives the same result as a fresh run.
